lsu_mem_ctrl: RTL and testbench

Load/store unit sitting in the MEM stage, consuming the RAM_write_en / RAM_read_en / RAM_ram_type / RAM_sign controls produced by the instruction decoder. It converts each access into a word-aligned request on a single-port data-memory bus with a req/gnt + rvalid handshake. It performs byte-lane steering and load sign/zero extension, detects misaligned or illegal accesses, and stalls the pipeline until the access completes.

---
 rtl/lsu_mem_ctrl_pkg.sv | 31 +++
 rtl/lsu_load_align.sv | 32 +++
 rtl/lsu_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings for the load/store unit: RAM access sizes, controller
// states and the access legality rule used at accept time.
package lsu_mem_ctrl_pkg;

  localparam logic [3:0] BYTE     = 4'b0001;
  localparam logic [3:0] HALFWORD = 4'b0011;
  localparam logic [3:0] FULLWORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } lsu_state_e;

  // Natural alignment per size; unknown sizes and load+store together are illegal.
  function automatic logic access_legal(input logic [3:0] ram_type,
                                        input logic [1:0] ofs,
                                        input logic       we,
                                        input logic       re);
    logic ok;
    case (ram_type)
      BYTE:     ok = 1'b1;
      HALFWORD: ok = ~ofs[0];
      FULLWORD: ok = (ofs == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok & ~(we & re);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it to 32 bits.
module lsu_load_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [3:0]  ram_type_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = mem_rdata_i[7:0];
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    case (ram_type_i)
      BYTE:     data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      HALFWORD: data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default:  data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: turns decoder load/store controls into a
// word-aligned req/gnt + rvalid bus access and stalls the pipeline meanwhile.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        RAM_write_en,
  input  logic        RAM_read_en,
  input  logic [3:0]  RAM_ram_type,
  input  logic        RAM_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q;
  logic [1:0]  ofs_q;
  logic [3:0]  type_q;
  logic        sign_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [31:0] load_data_q;
  logic        load_valid_q, misalign_q, bus_err_q;

  logic        start, legal, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_data;

  assign start   = req_valid & (RAM_write_en | RAM_read_en);
  assign legal   = access_legal(RAM_ram_type, addr[1:0], RAM_write_en, RAM_read_en);
  assign timeout = (cnt_q == TO_LAST);

  // Narrow stores are replicated across lanes; the byte enables select the target.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    case (RAM_ram_type)
      BYTE: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      HALFWORD: begin
        be_d    = 4'b0011 << addr[1:0];
        wdata_d = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign stall = (state_q == S_REQ) || (state_q == S_WAIT_R) ||
                 ((state_q == S_IDLE) && start);

  lsu_load_align u_load_align (
    .mem_rdata_i (mem_rdata),
    .offset_i    (ofs_q),
    .ram_type_i  (type_q),
    .sign_i      (sign_q),
    .data_o      (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ofs_q        <= 2'd0;
      type_q       <= 4'd0;
      sign_q       <= 1'b0;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ofs_q  <= addr[1:0];
            type_q <= RAM_ram_type;
            sign_q <= RAM_sign;
            cnt_q  <= 8'd0;
            if (legal) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= RAM_write_en;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              state_q     <= S_REQ;
            end else begin
              misalign_q <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_REQ: begin
          // A grant in the last allowed cycle still wins over the timeout.
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= 8'd0;
            state_q   <= mem_we_q ? S_DONE : S_WAIT_R;
          end else if (timeout) begin
            mem_req_q <= 1'b0;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WAIT_R: begin
          if (mem_rvalid) begin
            load_data_q  <= ext_data;
            load_valid_q <= 1'b1;
            cnt_q        <= 8'd0;
            state_q      <= S_DONE;
          end else if (timeout) begin
            bus_err_q <= 1'b1;
            cnt_q     <= 8'd0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl: a transaction-level model predicts every
// cycle's outputs, and directed accesses pin that model to literal values.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, RAM_write_en, RAM_read_en, RAM_sign;
  logic [3:0]  RAM_ram_type;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, misalign_err, bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .RAM_write_en(RAM_write_en), .RAM_read_en(RAM_read_en),
    .RAM_ram_type(RAM_ram_type), .RAM_sign(RAM_sign),
    .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .misalign_err(misalign_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int stall_hi = 0, req_hi = 0, lv_cnt = 0, mis_cnt = 0, berr_cnt = 0;
  int s_stall, s_req, s_lv, s_mis, s_berr;
  logic [31:0] cap_addr = 32'd0, cap_wd = 32'd0;
  logic [3:0]  cap_be = 4'd0;

  // Expected outputs for the current cycle
  bit          chk_en = 1'b0, chk_bus = 1'b0;
  logic        e_stall, e_req, e_lv, e_mis, e_berr, e_we;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_be;
  logic [31:0] model_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("load_valid", 32'(load_valid), 32'(e_lv));
      chk("misalign_err", 32'(misalign_err), 32'(e_mis));
      chk("bus_err", 32'(bus_err), 32'(e_berr));
      chk("load_data", load_data, e_ld);
      if (chk_bus) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      stall_hi += int'(stall);
      req_hi   += int'(mem_req);
      lv_cnt   += int'(load_valid);
      mis_cnt  += int'(misalign_err);
      berr_cnt += int'(bus_err);
      if (mem_req) begin
        cap_addr = mem_addr;
        cap_be   = mem_be;
        cap_wd   = mem_wdata;
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int size_m(input logic [3:0] t);
    if (t == BYTE) return 1;
    if (t == HALFWORD) return 2;
    if (t == FULLWORD) return 4;
    return 0;
  endfunction

  function automatic bit legal_m(input bit we, input bit re, input logic [3:0] t, input logic [31:0] a);
    int sz = size_m(t);
    if (we && re) return 1'b0;
    if (sz == 0) return 1'b0;
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [3:0] be_m(input logic [3:0] t, input logic [31:0] a);
    int sz = size_m(t);
    int o = int'(a[1:0]);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + sz);
    return be;
  endfunction

  function automatic logic [31:0] wdata_m(input logic [3:0] t, input logic [31:0] wd);
    int sz = size_m(t);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++)
      r = r | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] ext_m(input logic [3:0] t, input bit sg, input logic [31:0] a, input logic [31:0] rd);
    int sz = size_m(t);
    logic [31:0] v, mask, msb;
    if (sz == 4) return rd;
    v    = rd >> (8 * int'(a[1:0]));
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    msb  = (sz == 1) ? 32'h80 : 32'h8000;
    v    = v & mask;
    if (sg && ((v & msb) != 0)) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_exp();
    e_stall = 1'b0; e_req = 1'b0; e_lv = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
    chk_bus = 1'b0; e_ld = model_ld;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_stall = stall_hi; s_req = req_hi; s_lv = lv_cnt; s_mis = mis_cnt; s_berr = berr_cnt;
  endtask

  // gw: wait cycles before gnt; rw: wait cycles after gnt before rvalid (>= TO means never)
  task automatic run_txn(input bit we, input bit re, input logic [3:0] t, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int gw, input int rw, input bit stray);
    int k, r;
    bit granted, got;
    cyc();
    req_valid = 1'b1; RAM_write_en = we; RAM_read_en = re; RAM_ram_type = t;
    RAM_sign = sg; addr = a; wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = stray && ($urandom_range(0, 1) == 1); mem_rdata = $urandom;
    idle_exp(); e_stall = 1'b1;
    if (!legal_m(we, re, t, a)) begin
      cyc();
      mem_rvalid = stray && ($urandom_range(0, 1) == 1);
      idle_exp(); e_mis = 1'b1;
      return;
    end
    granted = (gw + 1 <= TO);
    k = granted ? gw + 1 : TO;
    for (int j = 1; j <= k; j++) begin
      cyc();
      mem_gnt = granted && (j == k);
      mem_rvalid = stray && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      idle_exp(); e_stall = 1'b1; e_req = 1'b1; chk_bus = 1'b1;
      e_we = we; e_addr = {a[31:2], 2'b00}; e_be = be_m(t, a); e_wdata = wdata_m(t, wd);
    end
    if (!granted || we) begin
      cyc();
      mem_gnt = 1'b0; mem_rvalid = stray && ($urandom_range(0, 1) == 1);
      idle_exp(); e_berr = !granted;
      return;
    end
    got = (rw + 1 <= TO);
    r = got ? rw + 1 : TO;
    for (int j = 1; j <= r; j++) begin
      cyc();
      mem_gnt = stray && ($urandom_range(0, 1) == 1);
      mem_rvalid = got && (j == r);
      mem_rdata = (got && (j == r)) ? rd : $urandom;
      idle_exp(); e_stall = 1'b1;
    end
    cyc();
    mem_gnt = 1'b0; mem_rvalid = stray && ($urandom_range(0, 1) == 1); mem_rdata = $urandom;
    if (got) model_ld = ext_m(t, sg, a, rd);
    idle_exp(); e_lv = got; e_berr = !got;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      req_valid = ($urandom_range(0, 1) == 1);
      RAM_write_en = !req_valid && ($urandom_range(0, 1) == 1);
      RAM_read_en  = !req_valid && ($urandom_range(0, 1) == 1);
      RAM_ram_type = 4'($urandom);
      addr = $urandom; wdata = $urandom;
      mem_gnt = ($urandom_range(0, 1) == 1);
      mem_rvalid = ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      idle_exp();
    end
  endtask

  initial begin
    logic [3:0] t;
    logic [31:0] a;
    bit we, re;
    int sel, g, rv;

    req_valid = 0; RAM_write_en = 0; RAM_read_en = 0; RAM_ram_type = 0; RAM_sign = 0;
    addr = 0; wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    model_ld = 32'd0;
    idle_exp(); chk_bus = 1'b1; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    chk_en = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1; chk_bus = 1'b0;
    idle_gap(2);

    snap(); run_txn(1, 0, FULLWORD, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0); idle_gap(1);
    chk("sw_stall_cycles", 32'(stall_hi - s_stall), 32'd2);
    chk("sw_addr", cap_addr, 32'h100);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_wdata", cap_wd, 32'hDEADBEEF);

    run_txn(1, 0, BYTE, 0, 32'h103, 32'h000000A5, 0, 0, 0, 0); idle_gap(1);
    chk("sb_be", 32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wd, 32'hA5A5A5A5);

    snap(); run_txn(0, 1, BYTE, 1, 32'h102, 0, 32'h1280FF34, 0, 0, 0); idle_gap(1);
    chk("lb_signed", load_data, 32'hFFFFFF80);
    chk("lb_stall_cycles", 32'(stall_hi - s_stall), 32'd3);
    run_txn(0, 1, BYTE, 0, 32'h102, 0, 32'h1280FF34, 0, 0, 0); idle_gap(1);
    chk("lb_unsigned", load_data, 32'h00000080);

    snap(); run_txn(0, 1, HALFWORD, 1, 32'h101, 0, 0, 0, 0, 0); idle_gap(1);
    chk("lh_mis_pulse", 32'(mis_cnt - s_mis), 32'd1);
    chk("lh_no_req", 32'(req_hi - s_req), 32'd0);
    chk("lh_stall_cycles", 32'(stall_hi - s_stall), 32'd1);
    snap(); run_txn(0, 1, FULLWORD, 0, 32'h106, 0, 0, 0, 0, 0); idle_gap(1);
    chk("lw_mis_pulse", 32'(mis_cnt - s_mis), 32'd1);

    snap(); run_txn(0, 1, FULLWORD, 0, 32'h40, 0, 32'hCAFEF00D, 3, 2, 0); idle_gap(1);
    chk("lw_slow_req_cycles", 32'(req_hi - s_req), 32'd4);
    chk("lw_slow_lv", 32'(lv_cnt - s_lv), 32'd1);
    chk("lw_slow_data", load_data, 32'hCAFEF00D);

    snap(); run_txn(0, 1, FULLWORD, 0, 32'h80, 0, 32'h11111111, 0, 9, 0); idle_gap(1);
    chk("lw_to_berr", 32'(berr_cnt - s_berr), 32'd1);
    chk("lw_to_no_lv", 32'(lv_cnt - s_lv), 32'd0);
    chk("lw_to_keep", load_data, 32'hCAFEF00D);
    snap(); run_txn(1, 0, FULLWORD, 0, 32'h84, 32'h5, 0, 9, 0, 0); idle_gap(1);
    chk("sw_to_berr", 32'(berr_cnt - s_berr), 32'd1);
    chk("sw_to_req_cycles", 32'(req_hi - s_req), 32'd4);

    // Reset pulsed while waiting for read data
    cyc();
    req_valid = 1; RAM_write_en = 0; RAM_read_en = 1; RAM_ram_type = FULLWORD;
    addr = 32'h300; mem_gnt = 0; mem_rvalid = 0;
    idle_exp(); e_stall = 1;
    cyc();
    mem_gnt = 1;
    idle_exp(); e_stall = 1; e_req = 1; chk_bus = 1; e_we = 0; e_addr = 32'h300;
    e_be = 4'hF; e_wdata = wdata;
    cyc(); mem_gnt = 0; idle_exp(); e_stall = 1;
    cyc(); idle_exp(); e_stall = 1;
    @(negedge clk); #1;
    rst_n = 1'b0; req_valid = 0; RAM_read_en = 0;
    #1;
    chk("rst_async_req", 32'(mem_req), 32'd0);
    chk("rst_async_stall", 32'(stall), 32'd0);
    model_ld = 32'd0;
    idle_exp(); chk_bus = 1; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    cyc(); cyc();
    rst_n = 1'b1; chk_bus = 0;
    snap();
    cyc(); mem_rvalid = 1; mem_rdata = 32'h99999999; idle_exp();
    cyc(); mem_rvalid = 0; idle_exp();
    idle_gap(1);
    chk("late_rvalid_no_lv", 32'(lv_cnt - s_lv), 32'd0);

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      t = (sel < 3) ? BYTE : (sel < 6) ? HALFWORD : (sel < 9) ? FULLWORD : 4'($urandom);
      we = ($urandom_range(0, 1) == 1);
      re = !we;
      if ($urandom_range(0, 15) == 0) begin we = 1; re = 1; end
      a = $urandom;
      if ((t == HALFWORD) && ($urandom_range(0, 3) != 0)) a[0] = 1'b0;
      if ((t == FULLWORD) && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
      g  = $urandom_range(0, 5);
      rv = $urandom_range(0, 5);
      run_txn(we, re, t, ($urandom_range(0, 1) == 1), a, $urandom, $urandom,
              (g == 5) ? 9 : g, (rv == 5) ? 9 : rv, 1'b1);
      idle_gap($urandom_range(0, 2));
    end
    idle_gap(2);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
